// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a single active-low row drive, samples the
// synchronized columns, debounces a single key press/release and reports it.
module keypad_scanner #(
  parameter int unsigned SCAN_DWELL = 4,
  parameter int unsigned DEBOUNCE   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n_in,
  output logic [3:0] row_n,
  output logic [3:0] row_onehot,
  output logic [3:0] col_onehot,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int unsigned DW_W = $clog2(SCAN_DWELL);
  localparam int unsigned DB_W = $clog2(DEBOUNCE);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DWELL - 1);
  localparam logic [DB_W-1:0] DEB_LAST   = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t          state, state_d;
  logic [1:0]      row_idx, row_idx_d;
  logic [DW_W-1:0] dwell_cnt, dwell_cnt_d;
  logic [DB_W-1:0] deb_cnt, deb_cnt_d;
  logic [1:0]      key_row, key_row_d;
  logic [3:0]      key_col, key_col_d;
  logic [3:0]      row_onehot_d, col_onehot_d;
  logic            key_valid_d, key_strobe_d;

  logic [3:0] col_meta, col_s;
  logic       single_col;
  logic       key_closed;

  // Inverted ahead of the flops so a cleared synchronizer means "no key closed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '0;
      col_s    <= '0;
    end else begin
      col_meta <= ~col_n_in;
      col_s    <= col_meta;
    end
  end

  assign row_n      = ~(4'b0001 << row_idx);
  assign single_col = (col_s != 4'b0000) && ((col_s & (col_s - 4'd1)) == 4'b0000);
  assign key_closed = |(col_s & key_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SCAN;
      row_idx    <= '0;
      dwell_cnt  <= '0;
      deb_cnt    <= '0;
      key_row    <= '0;
      key_col    <= '0;
      row_onehot <= '0;
      col_onehot <= '0;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_d;
      row_idx    <= row_idx_d;
      dwell_cnt  <= dwell_cnt_d;
      deb_cnt    <= deb_cnt_d;
      key_row    <= key_row_d;
      key_col    <= key_col_d;
      row_onehot <= row_onehot_d;
      col_onehot <= col_onehot_d;
      key_valid  <= key_valid_d;
      key_strobe <= key_strobe_d;
    end
  end

  always_comb begin
    state_d      = state;
    row_idx_d    = row_idx;
    dwell_cnt_d  = dwell_cnt;
    deb_cnt_d    = deb_cnt;
    key_row_d    = key_row;
    key_col_d    = key_col;
    row_onehot_d = row_onehot;
    col_onehot_d = col_onehot;
    key_valid_d  = key_valid;
    key_strobe_d = 1'b0;

    case (state)
      ST_SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt_d = '0;
          if (single_col) begin
            state_d   = ST_DEBOUNCE;
            key_row_d = row_idx;
            key_col_d = col_s;
            deb_cnt_d = '0;
          end else begin
            row_idx_d = row_idx + 2'd1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (col_s == key_col) begin
          if (deb_cnt == DEB_LAST) begin
            state_d      = ST_HELD;
            row_onehot_d = 4'b0001 << key_row;
            col_onehot_d = key_col;
            key_valid_d  = 1'b1;
            key_strobe_d = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt + 1'b1;
          end
        end else begin
          state_d     = ST_SCAN;
          row_idx_d   = row_idx + 2'd1;
          dwell_cnt_d = '0;
        end
      end

      ST_HELD: begin
        if (!key_closed) begin
          state_d   = ST_RELEASE;
          deb_cnt_d = '0;
        end
      end

      ST_RELEASE: begin
        if (!key_closed) begin
          if (deb_cnt == DEB_LAST) begin
            state_d      = ST_SCAN;
            row_idx_d    = key_row + 2'd1;
            dwell_cnt_d  = '0;
            row_onehot_d = '0;
            col_onehot_d = '0;
            key_valid_d  = 1'b0;
          end else begin
            deb_cnt_d = deb_cnt + 1'b1;
          end
        end else begin
          state_d = ST_HELD;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

endmodule
